// File: rtl/instr_issue_if.sv
// rtl/instr_issue_if.sv - fetch/issue/feedback signal bundle for the instr_issue stage
interface instr_issue_if #(
    parameter int DEPTH = 4,
    parameter int PCW   = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic           in_valid;
    logic           in_ready;
    logic [15:0]    in_instr;
    logic [PCW-1:0] in_pc;
    logic [4:0]     opcode;
    logic [1:0]     op_ext;
    logic           issue_valid;
    logic [PCW-1:0] issue_pc;
    logic           halt;
    logic           stall_ex;
    logic           redirect;
    logic           halted;
    logic [CW-1:0]  fifo_count;
    logic [15:0]    perf_issued;
    logic [15:0]    perf_bubbles;

    modport master (
        input  in_valid, in_instr, in_pc, halt, stall_ex, redirect,
        output in_ready, opcode, op_ext, issue_valid, issue_pc, halted,
               fifo_count, perf_issued, perf_bubbles
    );

    modport slave (
        output in_valid, in_instr, in_pc, halt, stall_ex, redirect,
        input  in_ready, opcode, op_ext, issue_valid, issue_pc, halted,
               fifo_count, perf_issued, perf_bubbles
    );
endinterface

// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - prefetch FIFO plus registered issue slot feeding the control decoder
// Optional perf counters enabled by defining ISSUE_PERF_EN.
module instr_issue #(
    parameter int DEPTH = 4,
    parameter int PCW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_issue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PCW + 16;

    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic [EW-1:0]  mem_d [DEPTH];
    logic           issue_valid_q, issue_valid_d;
    logic [15:0]    issue_instr_q, issue_instr_d;
    logic [PCW-1:0] issue_pc_q, issue_pc_d;

    logic run, in_ready, push, pop, advance, take_halt, fifo_empty;

    always_comb begin
        run        = (state_q == RUN);
        fifo_empty = (count_q == '0);
        in_ready   = (count_q < CW'(DEPTH)) && run && !bus.redirect;
        push       = bus.in_valid && in_ready;
        take_halt  = run && issue_valid_q && bus.halt && !bus.stall_ex && !bus.redirect;
        advance    = run && !bus.redirect && (!issue_valid_q || !bus.stall_ex);
        // The halting instruction retires without pulling a successor into the slot.
        pop        = advance && !take_halt && !fifo_empty;
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        mem_d         = mem_q;
        issue_valid_d = issue_valid_q;
        issue_instr_d = issue_instr_q;
        issue_pc_d    = issue_pc_q;

        if (push) begin
            mem_d[wr_ptr_q] = {bus.in_pc, bus.in_instr};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (advance && !take_halt) begin
            issue_valid_d = !fifo_empty;
            if (!fifo_empty) begin
                {issue_pc_d, issue_instr_d} = mem_q[rd_ptr_q];
                rd_ptr_d                    = rd_ptr_q + AW'(1);
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            RUN: begin
                if (take_halt) begin
                    state_d       = HALTED;
                    issue_valid_d = 1'b0;
                end
            end
            FLUSH:   state_d = RUN;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase

        // Redirect wins over halt and over any push/pop decided above.
        if (bus.redirect && state_q != HALTED) begin
            state_d       = FLUSH;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_instr_q <= '0;
            issue_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
            issue_pc_q    <= issue_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready    = in_ready;
    assign bus.opcode      = issue_instr_q[15:11];
    assign bus.op_ext      = issue_instr_q[1:0];
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_pc    = issue_pc_q;
    assign bus.halted      = (state_q == HALTED);
    assign bus.fifo_count  = count_q;

`ifdef ISSUE_PERF_EN
    logic [15:0] perf_issued_q, perf_issued_d;
    logic [15:0] perf_bubbles_q, perf_bubbles_d;
    logic        consume;

    always_comb begin
        consume        = issue_valid_q && !bus.stall_ex && !bus.redirect;
        perf_issued_d  = perf_issued_q;
        perf_bubbles_d = perf_bubbles_q;
        if (consume && perf_issued_q != 16'hFFFF)
            perf_issued_d = perf_issued_q + 16'd1;
        if (run && !issue_valid_q && perf_bubbles_q != 16'hFFFF)
            perf_bubbles_d = perf_bubbles_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q  <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign bus.perf_issued  = perf_issued_q;
    assign bus.perf_bubbles = perf_bubbles_q;
`else
    assign bus.perf_issued  = 16'd0;
    assign bus.perf_bubbles = 16'd0;
`endif
endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Front-end issue stage that drives the combinational control decoder: it is the opcode/op_ext producer.
- Buffers fetched 16-bit instruction words in a small prefetch FIFO.
- Presents one instruction per cycle to the decoder through a registered issue slot.
- Reacts to decoder feedback (halt) and execute-stage feedback (redirect, stall_ex).

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.
- PCW, 16, width of PC tag carried with each instruction.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch word valid.
- in_ready  output  1  FIFO can accept word.
- in_instr  input  16  instruction word.
- in_pc  input  PCW  PC of in_instr.
- opcode  output  5  to decoder; equals issue_instr[15:11].
- op_ext  output  2  to decoder; equals issue_instr[1:0].
- issue_valid  output  1  issue slot holds a live instruction.
- issue_pc  output  PCW  PC of issued instruction.
- halt  input  1  decoder halt output, combinational from opcode.
- stall_ex  input  1  execute cannot take issue slot this cycle.
- redirect  input  1  single-cycle pulse; taken branch/jump resolved in execute; squash younger work.
- halted  output  1  core halted.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- perf_issued  output  16  issued-instruction counter (see optional feature).
- perf_bubbles  output  16  empty-slot cycle counter (see optional feature).

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count=0; issue_valid=0; opcode=0; op_ext=0; issue_pc=0; halted=0; state=RUN; perf counters=0.
- States: RUN, FLUSH, HALTED.
- Push: when in_valid && in_ready, write {in_pc,in_instr} at tail.
  - in_ready = (count<DEPTH) && state==RUN && !redirect.
  - Full is judged on registered count: no push into a full FIFO even if a pop occurs the same cycle.
- Advance condition: state==RUN && !redirect && (!issue_valid || !stall_ex).
  - If advance and FIFO non-empty: pop head into issue slot; issue_valid=1 next cycle.
  - If advance and FIFO empty: issue_valid=0 next cycle (bubble).
  - If stall_ex && issue_valid: slot, opcode, op_ext and issue_pc hold unchanged.
- Empty FIFO with simultaneous push: the word is not bypassed; it issues no earlier than the following cycle. Latency from push to issue_valid is 2 cycles minimum.
- Halt: when state==RUN && issue_valid && halt && !stall_ex && !redirect:
  - the halting instruction counts as consumed;
  - next cycle state=HALTED, issue_valid=0, halted=1;
  - no further pops or pushes.
  - HALTED is exited only by reset.
- Redirect (any state except HALTED):
  - FIFO pointers and count clear next cycle;
  - issue_valid=0 next cycle;
  - state=FLUSH for exactly one cycle (in_ready=0, no pop), then RUN.
  - Redirect beats halt in the same cycle: the halt in the slot is squashed, state goes to FLUSH, not HALTED.
  - Redirect during FLUSH restarts FLUSH for one more cycle.
- halt is ignored when issue_valid=0. Opcode 0 after reset must never halt the core.
- Pointer wrap is modulo DEPTH. count increments on push only, decrements on pop only, and is unchanged on push+pop.
- fifo_count is registered occupancy.

Optional Feature:
- ISSUE_PERF_EN defined:
  - perf_issued increments on each cycle an issued instruction is consumed (issue_valid && !stall_ex && !redirect).
  - perf_bubbles increments each RUN cycle with issue_valid=0.
  - Both counters saturate at 16'hFFFF and clear on reset only.
- ISSUE_PERF_EN undefined: no counter logic; perf_issued and perf_bubbles tied to 0.

Test Plan:
- Push 0x0801@pc0x10, 0x1002@pc0x12 back-to-back, stall_ex=0:
  - issue_valid rises 2 cycles after first push;
  - opcode=5'h01, op_ext=2'b01, issue_pc=0x10;
  - next cycle opcode=5'h02, op_ext=2'b10, issue_pc=0x12.
- Fill FIFO with 4 words while stall_ex=1 and slot occupied: in_ready=0 at fifo_count=4. Release stall: one pop per cycle, fifo_count 4→3→2→1→0.
- Issue word whose decode drives halt=1 with stall_ex=0: next cycle halted=1, issue_valid=0, in_ready=0; state persists for 20 cycles with in_valid=1.
- Same halt word with redirect=1 in the same cycle: halted stays 0, fifo_count=0 next cycle, in_ready=0 for 1 cycle, then 1.
- Assert rst_n=0 mid-stream with fifo_count=3 and issue_valid=1: all outputs return to reset values immediately, without waiting for a clock edge.
- With ISSUE_PERF_EN: 5 issues plus 3 empty cycles → perf_issued=5, perf_bubbles=3. Without the macro both read 0.
